// File: rtl/expstate_pkg.sv
// Shared defaults and width helpers for the exported-state change FIFO.
package expstate_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int CNT_WIDTH_DEF  = 16;

    // LEVEL must represent 0..DEPTH inclusive, hence one bit above the pointer width.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/expstate_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
module expstate_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the top masks the head while empty.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/expstate_change_fifo.sv
// Detects every change of the exported-state bus and queues each new value for a valid/ready consumer.
module expstate_change_fifo
    import expstate_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [DATA_WIDTH-1:0]         TIE_EXPSTATE,
    output logic [DATA_WIDTH-1:0]         OUT_DATA,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [level_width(DEPTH)-1:0] LEVEL,
    output logic [CNT_WIDTH-1:0]          CHANGE_COUNT,
    output logic [CNT_WIDTH-1:0]          DROP_COUNT,
    output logic                          OVERFLOW,
    input  logic                          CLEAR_OVF
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [LW-1:0]         level_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] head;
    logic                  change;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // Handshake: the head transfers at a rising edge where OUT_VALID && OUT_READY; OUT_VALID
    // is a register, so OUT_READY only influences the following edge, and the head holds until taken.
    always_comb begin
        change = (TIE_EXPSTATE != prev);
        full   = (level_q == LW'(DEPTH));
        pop    = valid_q && OUT_READY;
        push   = change && (!full || pop);
        drop   = change && !push;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev         <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            level_q      <= '0;
            valid_q      <= 1'b0;
            CHANGE_COUNT <= '0;
            DROP_COUNT   <= '0;
            OVERFLOW     <= 1'b0;
        end else begin
            prev <= TIE_EXPSTATE;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10: begin
                    level_q <= level_q + LW'(1);
                    valid_q <= 1'b1;
                end
                2'b01: begin
                    level_q <= level_q - LW'(1);
                    valid_q <= (level_q != LW'(1));
                end
                default: ;
            endcase
            if (change) begin
                CHANGE_COUNT <= CHANGE_COUNT + CNT_WIDTH'(1);
            end
            if (drop && (DROP_COUNT != '1)) begin
                DROP_COUNT <= DROP_COUNT + CNT_WIDTH'(1);
            end
            // A drop at the same edge as a clear keeps the flag set.
            if (drop) begin
                OVERFLOW <= 1'b1;
            end else if (CLEAR_OVF) begin
                OVERFLOW <= 1'b0;
            end
        end
    end

    expstate_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk  (CLK),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(TIE_EXPSTATE),
        .raddr(rd_ptr),
        .rdata(head)
    );

    assign OUT_VALID = valid_q;
    assign OUT_DATA  = valid_q ? head : '0;
    assign LEVEL     = level_q;

endmodule

// File: tb/tb_expstate_change_fifo.sv
// Self-checking bench for expstate_change_fifo: reference queue plus counter/flag model.
module tb_expstate_change_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          CLK;
    logic          RESET;
    logic [DW-1:0] TIE_EXPSTATE;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [LW-1:0] LEVEL;
    logic [CW-1:0] CHANGE_COUNT;
    logic [CW-1:0] DROP_COUNT;
    logic          OVERFLOW;
    logic          CLEAR_OVF;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_prev;
    logic [CW-1:0] exp_change;
    logic [CW-1:0] exp_drop;
    logic          exp_ovf;

    expstate_change_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .TIE_EXPSTATE(TIE_EXPSTATE),
        .OUT_DATA    (OUT_DATA),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .LEVEL       (LEVEL),
        .CHANGE_COUNT(CHANGE_COUNT),
        .DROP_COUNT  (DROP_COUNT),
        .OVERFLOW    (OVERFLOW),
        .CLEAR_OVF   (CLEAR_OVF)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic model_reset();
        exp_q.delete();
        m_prev     = '0;
        exp_change = '0;
        exp_drop   = '0;
        exp_ovf    = 1'b0;
    endtask

    // Driver: apply inputs (called at a falling edge), clock one rising edge, update the model,
    // return at the next falling edge where the bench samples outputs.
    task automatic step(input logic [DW-1:0] d, input logic rdy, input logic clr);
        logic          do_pop;
        logic          was_full;
        logic [DW-1:0] tmp;
        TIE_EXPSTATE = d;
        OUT_READY    = rdy;
        CLEAR_OVF    = clr;
        @(posedge CLK);
        do_pop   = rdy && (exp_q.size() != 0);
        was_full = (exp_q.size() == DEPTH);
        if (do_pop) tmp = exp_q.pop_front();
        if (d != m_prev) begin
            exp_change = exp_change + 1'b1;
            if (!was_full || do_pop) begin
                exp_q.push_back(d);
            end else begin
                if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 1'b1;
                exp_ovf = 1'b1;
            end
        end else if (clr) begin
            exp_ovf = 1'b0;
        end
        if ((d != m_prev) && was_full && !do_pop) exp_ovf = 1'b1;
        else if (clr && !((d != m_prev) && was_full && !do_pop)) exp_ovf = 1'b0;
        m_prev = d;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) step('0, 1'b0, 1'b0);
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid act=%0b exp=0", OUT_VALID); end
        checks++; if (CHANGE_COUNT !== '0) begin errors++; $display("FAIL reset_change act=%0d exp=0", CHANGE_COUNT); end
        checks++; if (LEVEL !== '0) begin errors++; $display("FAIL reset_level act=%0d exp=0", LEVEL); end
        checks++; if (OUT_DATA !== '0) begin errors++; $display("FAIL reset_data act=%h exp=0", OUT_DATA); end
        checks++; if ({DROP_COUNT, OVERFLOW} !== '0) begin errors++; $display("FAIL reset_drop_ovf act=%0d/%0b exp=0/0", DROP_COUNT, OVERFLOW); end
    endtask

    task automatic test_order();
        logic [DW-1:0] vals [4] = '{32'h11, 32'h22, 32'h22, 32'h33};
        for (int i = 0; i < 4; i++) step(vals[i], 1'b0, 1'b0);
        checks++; if (LEVEL !== LW'(3)) begin errors++; $display("FAIL order_level act=%0d exp=3", LEVEL); end
        checks++; if (CHANGE_COUNT !== CW'(3)) begin errors++; $display("FAIL order_change act=%0d exp=3", CHANGE_COUNT); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (OUT_VALID !== 1'b1 || exp_q.size() == 0 || OUT_DATA !== exp_q[0]) begin
                errors++; $display("FAIL order_pop%0d act=%h/%0b exp=%h", i, OUT_DATA, OUT_VALID, (exp_q.size() != 0) ? exp_q[0] : '0);
            end
            step(32'h33, 1'b1, 1'b0);
        end
        checks++; if (OUT_VALID !== 1'b0 || OUT_DATA !== '0 || LEVEL !== '0) begin
            errors++; $display("FAIL order_empty act=%0b/%h/%0d exp=0/0/0", OUT_VALID, OUT_DATA, LEVEL);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) step(32'h100 + i, 1'b0, 1'b0);
        checks++; if (LEVEL !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_level act=%0d exp=%0d", LEVEL, DEPTH); end
        checks++; if (DROP_COUNT !== CW'(2) || DROP_COUNT !== exp_drop) begin errors++; $display("FAIL ovf_drop act=%0d exp=2", DROP_COUNT); end
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag act=%0b exp=1", OVERFLOW); end
        checks++; if (CHANGE_COUNT !== exp_change) begin errors++; $display("FAIL ovf_change act=%0d exp=%0d", CHANGE_COUNT, exp_change); end
        checks++; if (OUT_DATA !== 32'h100) begin errors++; $display("FAIL ovf_head act=%h exp=100", OUT_DATA); end
    endtask

    task automatic test_full_push_pop();
        step(32'hA5, 1'b1, 1'b0);
        checks++; if (LEVEL !== LW'(DEPTH)) begin errors++; $display("FAIL fullpp_level act=%0d exp=%0d", LEVEL, DEPTH); end
        checks++; if (DROP_COUNT !== CW'(2)) begin errors++; $display("FAIL fullpp_drop act=%0d exp=2", DROP_COUNT); end
        checks++; if (OUT_DATA !== exp_q[0]) begin errors++; $display("FAIL fullpp_head act=%h exp=%h", OUT_DATA, exp_q[0]); end
        checks++; if (exp_q[DEPTH-1] !== 32'hA5) begin errors++; $display("FAIL fullpp_tail act=%h exp=a5", exp_q[DEPTH-1]); end
    endtask

    task automatic test_clear_ovf();
        int budget;
        step(32'hB6, 1'b0, 1'b1);
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL clr_set_wins act=%0b exp=1", OVERFLOW); end
        checks++; if (DROP_COUNT !== CW'(3)) begin errors++; $display("FAIL clr_drop3 act=%0d exp=3", DROP_COUNT); end
        step(32'hB6, 1'b0, 1'b1);
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL clr_cleared act=%0b exp=0", OVERFLOW); end
        checks++; if (DROP_COUNT !== CW'(3)) begin errors++; $display("FAIL clr_drop_kept act=%0d exp=3", DROP_COUNT); end
        CLEAR_OVF = 1'b0;
        budget = 0;
        while (exp_q.size() != 0 && budget < 2 * DEPTH) begin
            checks++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_q[0]) begin
                errors++; $display("FAIL drain act=%h/%0b exp=%h", OUT_DATA, OUT_VALID, exp_q[0]);
            end
            step(32'hB6, 1'b1, 1'b0);
            budget++;
        end
        checks++; if (exp_q.size() != 0 || OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL drain_done act=%0b/%0d exp=0/0", OUT_VALID, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            d = m_prev ^ ($urandom_range(32'h7FFF_FFFF, 0) | 32'h1);
            step(d, 1'b1, 1'b0);
            if (OUT_VALID !== 1'b1 || exp_q.size() != 1 || OUT_DATA !== exp_q[0] || LEVEL !== LW'(1)) begin
                bad++;
                if (bad == 1) $display("FAIL b2b_cycle%0d act=%h/%0d exp=%h/1", i, OUT_DATA, LEVEL, d);
            end
        end
        checks++; if (bad != 0) errors++;
        checks++; if (OVERFLOW !== 1'b0 || DROP_COUNT !== CW'(3)) begin
            errors++; $display("FAIL b2b_no_drop act=%0b/%0d exp=0/3", OVERFLOW, DROP_COUNT);
        end
        checks++; if (CHANGE_COUNT !== exp_change) begin errors++; $display("FAIL b2b_change act=%0d exp=%0d", CHANGE_COUNT, exp_change); end
        step(m_prev, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(32'h200 + i, 1'b0, 1'b0);
        checks++; if (LEVEL !== LW'(5)) begin errors++; $display("FAIL ares_level5 act=%0d exp=5", LEVEL); end
        #2 RESET = 1'b1;
        #1;
        checks++; if ({OUT_VALID, OUT_DATA, LEVEL, CHANGE_COUNT, DROP_COUNT, OVERFLOW} !== '0) begin
            errors++; $display("FAIL ares_outputs act=%0b/%h/%0d/%0d/%0d/%0b exp=all0", OUT_VALID, OUT_DATA, LEVEL, CHANGE_COUNT, DROP_COUNT, OVERFLOW);
        end
        TIE_EXPSTATE = '0;
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        step(32'h0, 1'b0, 1'b0);
        checks++; if (OUT_VALID !== 1'b0 || LEVEL !== '0 || CHANGE_COUNT !== '0) begin
            errors++; $display("FAIL ares_zero act=%0b/%0d/%0d exp=0/0/0", OUT_VALID, LEVEL, CHANGE_COUNT);
        end
        step(32'h5, 1'b0, 1'b0);
        checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 32'h5 || LEVEL !== LW'(1)) begin
            errors++; $display("FAIL ares_push act=%0b/%h/%0d exp=1/5/1", OUT_VALID, OUT_DATA, LEVEL);
        end
    endtask

    initial begin
        RESET        = 1'b1;
        TIE_EXPSTATE = '0;
        OUT_READY    = 1'b0;
        CLEAR_OVF    = 1'b0;
        model_reset();
        test_reset();
        test_order();
        test_overflow();
        test_full_push_pop();
        test_clear_ovf();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/expstate_change_fifo.md
# expstate_change_fifo

Captures every change of the 32-bit TIE exported-state bus driven by the Xtensa core in the XTSC Verilog co-simulation and queues each new value in a small FIFO. A valid/ready port drains the FIFO toward the co-simulated peripheral model. This gives the consumer a lossless, ordered history of state writes instead of a level that may change faster than it is sampled. It sits directly downstream of the core's TIE_EXPSTATE output, in parallel with the pass-through import-wire path.

## Interface
- DATA_WIDTH, 32: width of TIE_EXPSTATE and OUT_DATA.
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- CNT_WIDTH, 16: width of CHANGE_COUNT and DROP_COUNT.

Ports (clock and reset first):
- CLK  in  1  single clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- TIE_EXPSTATE  in  DATA_WIDTH  exported state from the core, sampled every edge.
- OUT_DATA  out  DATA_WIDTH  FIFO head value.
- OUT_VALID  out  1  FIFO not empty.
- OUT_READY  in  1  consumer accepts the head when OUT_VALID && OUT_READY.
- LEVEL  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- CHANGE_COUNT  out  CNT_WIDTH  changes detected since reset; wraps modulo 2^CNT_WIDTH.
- DROP_COUNT  out  CNT_WIDTH  changes lost to a full FIFO; saturates at all-ones.
- OVERFLOW  out  1  sticky; set when any change is dropped.
- CLEAR_OVF  in  1  synchronous clear of OVERFLOW.

## Operation
- prev register holds the last sampled TIE_EXPSTATE; it resets to 0.
- Change at an edge: TIE_EXPSTATE != prev. A first sample of 0 after reset is therefore not a change; any nonzero value is.
- prev <= TIE_EXPSTATE every edge, whether or not a change is detected.
- Change detected: CHANGE_COUNT += 1, then:
  - Push TIE_EXPSTATE when LEVEL < DEPTH, or when LEVEL == DEPTH and a pop occurs at the same edge (full with simultaneous pop is accepted).
  - Otherwise drop the value, set OVERFLOW, and DROP_COUNT += 1 (saturating).
- Pop: at an edge with OUT_VALID && OUT_READY, advance the read pointer.
- Push and pop at the same edge leave LEVEL unchanged.
- Pop while empty is a no-op.
- Pointers are $clog2(DEPTH) bits and wrap naturally; LEVEL is kept as an explicit counter.
- CLEAR_OVF: clears OVERFLOW. If a drop occurs at the same edge, set wins. CLEAR_OVF does not touch DROP_COUNT.
- Reset (asynchronous, any time, including mid-burst):
  - pointers and LEVEL = 0, OUT_VALID = 0, OUT_DATA = 0.
  - CHANGE_COUNT = 0, DROP_COUNT = 0, OVERFLOW = 0, prev = 0.
  - FIFO contents are discarded.
- OUT_DATA is 0 whenever the FIFO is empty. It is never stale.

## Timing
- Latency: a value present at edge k and different from prev appears on OUT_DATA with OUT_VALID = 1 after edge k, if the FIFO was empty. One cycle, no combinational path from TIE_EXPSTATE to any output.
- OUT_VALID, OUT_DATA, LEVEL, counters and OVERFLOW are all registered outputs.
- OUT_READY affects only the next edge; there is no combinational path from OUT_READY to OUT_VALID.
- Throughput: one push and one pop per cycle sustained. A bus toggling every cycle with OUT_READY held high never overflows.
- Valid/ready rule: once asserted, OUT_VALID stays high and OUT_DATA stays stable until popped.

## Structure
- Shared package expstate_pkg holds:
  - DATA_WIDTH and CNT_WIDTH defaults.
  - a level-width function, clog2(DEPTH)+1.
- Sub-module expstate_fifo_mem: DEPTH x DATA_WIDTH register array with write-enable/write-address and asynchronous read-address. Pointer, level and flag logic stay in the top.
- The $display/$dumpvars debug hooks are gated by the existing DISPLAY_IO define and the dumpvars plusarg.

## Test plan
- Reset then TIE_EXPSTATE held at 0 for 10 cycles -> OUT_VALID = 0, CHANGE_COUNT = 0, all outputs 0.
- Drive 0x11, 0x22, 0x22, 0x33 on consecutive edges with OUT_READY = 0 -> LEVEL = 3, CHANGE_COUNT = 3; then raising OUT_READY pops 0x11, 0x22, 0x33 in order.
- OUT_READY = 0, drive 10 distinct values with DEPTH = 8 -> LEVEL = 8, DROP_COUNT = 2, OVERFLOW = 1, and the FIFO holds the first 8 values.
- FIFO full; at one edge drive a new value 0xA5 with OUT_READY = 1 -> value accepted, LEVEL stays 8, DROP_COUNT unchanged.
- OVERFLOW = 1; assert CLEAR_OVF at the same edge as another drop -> OVERFLOW stays 1. Next edge, with CLEAR_OVF and no drop -> OVERFLOW = 0, DROP_COUNT retained.
- Assert RESET asynchronously mid-cycle with LEVEL = 5 -> all outputs 0 immediately. After release, driving 0x0 -> no push; driving 0x5 -> push.
